// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage.
//   WORD_W        : datapath / word-index width
//   NOP_INSTR     : encoding used for IF/ID bubbles
//   fetch_state_e : fetch FSM states
package mips_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register: instruction, PC+1 word index and valid bit.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   load           : capture load_instr / load_pc_plus1 and mark valid
//   flush          : force a bubble (takes priority over load)
//   load_instr     : instruction to capture
//   load_pc_plus1  : next sequential word index to capture
//   instr          : registered instruction (NOP when not valid)
//   pc_plus1       : registered PC+1 word index
//   valid          : register holds a real instruction
// With neither load nor flush asserted the contents hold.
module ifid_register
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              flush,
    input  logic [WORD_W-1:0] load_instr,
    input  logic [WORD_W-1:0] load_pc_plus1,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] pc_plus1,
    output logic              valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= NOP_INSTR;
            pc_plus1 <= '0;
            valid    <= 1'b0;
        end else if (flush) begin
            instr    <= NOP_INSTR;
            pc_plus1 <= '0;
            valid    <= 1'b0;
        end else if (load) begin
            instr    <= load_instr;
            pc_plus1 <= load_pc_plus1;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC (word index), drives instruction memory, fills IF/ID.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   stall_i          : hold PC and IF/ID
//   redirect_i       : taken branch/jump; PC <- redirect_pc_i, IF/ID bubbled
//   redirect_pc_i    : redirect target word index
//   imem_addr_o      : word index to instruction memory (PC flop)
//   imem_instr_i     : combinational instruction memory read data
//   ifid_instr_o     : IF/ID instruction (NOP when invalid)
//   ifid_pc_plus1_o  : IF/ID next sequential word index
//   ifid_valid_o     : IF/ID holds a real instruction
//   fetch_fault_o    : sticky out-of-range fetch flag
//   fetch_count_o    : instructions latched into IF/ID (wraps)
//
// State | Meaning
// ------+-------------------------------------------------------------
// RUN   | normal fetch; redirect > stall > range fault > sequential fetch
// HALT  | out-of-range fetch seen; everything frozen, IF/ID bubbled
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC   = 32'd0,
    parameter longint unsigned   IMEM_DEPTH = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [WORD_W-1:0] redirect_pc_i,
    output logic [WORD_W-1:0] imem_addr_o,
    input  logic [WORD_W-1:0] imem_instr_i,
    output logic [WORD_W-1:0] ifid_instr_o,
    output logic [WORD_W-1:0] ifid_pc_plus1_o,
    output logic              ifid_valid_o,
    output logic              fetch_fault_o,
    output logic [WORD_W-1:0] fetch_count_o
);

    localparam logic ST_RUN  = RUN;
    localparam logic ST_HALT = HALT;

    // One extra bit so a depth of exactly 2^32 means "never out of range".
    localparam logic [WORD_W:0] DEPTH_LIMIT = IMEM_DEPTH[WORD_W:0];

    logic              state;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus1;
    logic [WORD_W-1:0] count;
    logic              fault;

    logic running;
    logic out_of_range;
    logic take_redirect;
    logic fault_now;
    logic do_fetch;
    logic ifid_flush;

    assign pc_plus1      = pc + 32'd1;
    assign running       = (state == ST_RUN);
    assign out_of_range  = ({1'b0, pc} >= DEPTH_LIMIT);
    assign take_redirect = running & redirect_i;
    assign fault_now     = running & ~redirect_i & ~stall_i & out_of_range;
    assign do_fetch      = running & ~redirect_i & ~stall_i & ~out_of_range;
    // HALT re-bubbles IF/ID every cycle rather than relying on it staying empty.
    assign ifid_flush    = ~running | take_redirect | fault_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            pc    <= RESET_PC;
            count <= '0;
            fault <= 1'b0;
        end else begin
            if (take_redirect) begin
                pc <= redirect_pc_i;
            end else if (fault_now) begin
                fault <= 1'b1;
                state <= ST_HALT;
            end else if (do_fetch) begin
                pc    <= pc_plus1;
                count <= count + 32'd1;
            end
        end
    end

    ifid_register u_ifid (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (do_fetch),
        .flush         (ifid_flush),
        .load_instr    (imem_instr_i),
        .load_pc_plus1 (pc_plus1),
        .instr         (ifid_instr_o),
        .pc_plus1      (ifid_pc_plus1_o),
        .valid         (ifid_valid_o)
    );

    assign imem_addr_o   = pc;
    assign fetch_fault_o = fault;
    assign fetch_count_o = count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus1;
    logic        ifid_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:DEPTH-1];

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pp1;
        logic        valid;
        logic        fault;
        logic [31:0] count;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: architectural view of the fetch stage.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pp1;
    logic        m_valid;
    logic        m_fault;
    logic [31:0] m_count;
    logic        m_halt;

    instruction_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall),
        .redirect_i      (redirect),
        .redirect_pc_i   (redirect_pc),
        .imem_addr_o     (imem_addr),
        .imem_instr_i    (imem_instr),
        .ifid_instr_o    (ifid_instr),
        .ifid_pc_plus1_o (ifid_pc_plus1),
        .ifid_valid_o    (ifid_valid),
        .fetch_fault_o   (fetch_fault),
        .fetch_count_o   (fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_instr = (imem_addr < DEPTH) ? mem[imem_addr[6:0]] : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_instr = 32'd0; m_pp1 = 32'd0; m_valid = 1'b0;
        m_fault = 1'b0; m_count = 32'd0; m_halt = 1'b0;
    endtask

    task automatic model_bubble();
        m_instr = 32'd0; m_pp1 = 32'd0; m_valid = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic r, input logic [31:0] t);
        if (m_halt) begin
            model_bubble();
        end else if (r) begin
            m_pc = t;
            model_bubble();
        end else if (s) begin
            // nothing changes
        end else if (m_pc >= DEPTH) begin
            model_bubble();
            m_fault = 1'b1;
            m_halt = 1'b1;
        end else begin
            m_instr = mem[m_pc[6:0]];
            m_pp1 = m_pc + 1;
            m_valid = 1'b1;
            m_pc = m_pc + 1;
            m_count = m_count + 1;
        end
    endtask

    // Drive one cycle of inputs and queue the expected post-edge view.
    task automatic step(input logic s, input logic r, input logic [31:0] t);
        exp_t e;
        @(negedge clk);
        #1;
        stall = s;
        redirect = r;
        redirect_pc = t;
        model_edge(s, r, t);
        e.addr = m_pc; e.instr = m_instr; e.pp1 = m_pp1; e.valid = m_valid;
        e.fault = m_fault; e.count = m_count;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_addr"},  imem_addr, 32'd0);
        chk({tag, "_instr"}, ifid_instr, 32'd0);
        chk({tag, "_pp1"},   ifid_pc_plus1, 32'd0);
        chk({tag, "_valid"}, {31'd0, ifid_valid}, 32'd0);
        chk({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
        chk({tag, "_count"}, fetch_count, 32'd0);
    endtask

    // Reset pulse starting mid-cycle; released between an edge and the next step.
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        #1;
        check_reset_values(tag);
        exp_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Scoreboard monitor.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_addr",  imem_addr, e.addr);
            chk("sb_instr", ifid_instr, e.instr);
            chk("sb_pp1",   ifid_pc_plus1, e.pp1);
            chk("sb_valid", {31'd0, ifid_valid}, {31'd0, e.valid});
            chk("sb_fault", {31'd0, fetch_fault}, {31'd0, e.fault});
            chk("sb_count", fetch_count, e.count);
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'hACC5_0000;
        mem[1] = 32'h8C6A_0003;
        model_reset();

        // Power-on reset
        rst_n = 1'b0;
        #2;
        check_reset_values("por");
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Free run
        step(0, 0, 0);
        settle();
        chk("run0_instr", ifid_instr, 32'hACC5_0000);
        chk("run0_pp1", ifid_pc_plus1, 32'd1);
        step(0, 0, 0);
        settle();
        chk("run1_instr", ifid_instr, 32'h8C6A_0003);
        chk("run1_pp1", ifid_pc_plus1, 32'd2);
        chk("run1_count", fetch_count, 32'd2);

        // Stall at PC=4
        step(0, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        settle();
        chk("stall_addr", imem_addr, 32'd4);
        chk("stall_count", fetch_count, 32'd4);
        chk("stall_pp1", ifid_pc_plus1, 32'd4);
        step(0, 0, 0);
        settle();
        chk("resume_instr", ifid_instr, mem[4]);
        chk("resume_pp1", ifid_pc_plus1, 32'd5);

        // Redirect with simultaneous stall at PC=8
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        settle();
        chk("pre_redir_addr", imem_addr, 32'd8);
        step(1, 1, 32'd15);
        settle();
        chk("redir_valid", {31'd0, ifid_valid}, 32'd0);
        chk("redir_instr", ifid_instr, 32'd0);
        chk("redir_addr", imem_addr, 32'd15);
        step(0, 0, 0);
        settle();
        chk("tgt_instr", ifid_instr, mem[15]);
        chk("tgt_pp1", ifid_pc_plus1, 32'd16);

        // Randomized traffic, in-range targets only
        for (int i = 0; i < 300; i++) begin
            logic s, r;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 9) == 0);
            step(s, r, $urandom_range(0, DEPTH - 1));
        end

        // Run off the end of memory
        step(0, 1, 32'd120);
        for (int i = 0; i < 9; i++) step(0, 0, 0);
        settle();
        chk("end_fault", {31'd0, fetch_fault}, 32'd1);
        chk("end_valid", {31'd0, ifid_valid}, 32'd0);
        chk("end_addr", imem_addr, 32'd128);
        step(0, 1, 32'd0);
        step(1, 0, 0);
        settle();
        chk("halt_addr", imem_addr, 32'd128);
        chk("halt_fault", {31'd0, fetch_fault}, 32'd1);

        // Reset after 5 fetches
        reset_pulse("rst_a");
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        settle();
        chk("five_count", fetch_count, 32'd5);
        reset_pulse("rst_b");
        step(0, 0, 0);
        settle();
        chk("restart_instr", ifid_instr, 32'hACC5_0000);
        chk("restart_count", fetch_count, 32'd1);

        // Out-of-range redirect target
        step(0, 1, 32'd200);
        settle();
        chk("oor_valid", {31'd0, ifid_valid}, 32'd0);
        chk("oor_fault0", {31'd0, fetch_fault}, 32'd0);
        chk("oor_addr", imem_addr, 32'd200);
        step(0, 0, 0);
        settle();
        chk("oor_fault1", {31'd0, fetch_fault}, 32'd1);
        chk("oor_addr_hold", imem_addr, 32'd200);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
